// File: rtl/reg_stack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_stack_pkg                                                |
// | Description : Shared defaults and helpers for the register/stack bank.     |
// |               DATA_W_DEF / DEPTH_DEF give the default geometry; clog2 is   |
// |               used to derive address widths from DEPTH.                    |
// | Revision    : 1.0 - initial parametrised release                          |
// +----------------------------------------------------------------------------+
package reg_stack_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  // Smallest r with (1 << r) >= value; constant-evaluable for port widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_stack_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_stack_ptr                                                |
// | Description : Stack pointer, occupancy flags, push/pop qualification and   |
// |               sticky overflow/underflow error flags.                       |
// | Ports       : clk_i, rst_i        clock, async active-high reset           |
// |               push_i, pop_i       raw stack requests                       |
// |               err_clr_i           clears both sticky flags                 |
// |               sp_o                occupied entries (0..DEPTH)              |
// |               full_o, empty_o     occupancy flags                          |
// |               push_ok_o           push into entry sp (sp grows)            |
// |               pop_ok_o            pop from entry sp-1 (sp shrinks)         |
// |               replace_o           pop+push on entry sp-1 (sp unchanged)    |
// |               overflow_err_o      sticky: push while full                  |
// |               underflow_err_o     sticky: pop while empty                  |
// | Revision    : 1.0 - initial parametrised release                          |
// +----------------------------------------------------------------------------+
module reg_stack_ptr
  import reg_stack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SP_W  = clog2(DEPTH_DEF) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            err_clr_i,
  output logic [SP_W-1:0] sp_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            push_ok_o,
  output logic            pop_ok_o,
  output logic            replace_o,
  output logic            overflow_err_o,
  output logic            underflow_err_o
);

  logic [SP_W-1:0] sp_q, sp_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;

  assign sp_o            = sp_q;
  assign full_o          = (sp_q == SP_W'(DEPTH));
  assign empty_o         = (sp_q == '0);
  assign overflow_err_o  = ovf_q;
  assign underflow_err_o = udf_q;

  always_comb begin
    push_ok_o = 1'b0;
    pop_ok_o  = 1'b0;
    replace_o = 1'b0;
    sp_d      = sp_q;

    // Push+pop on an empty stack degrades to a plain push; otherwise it is a
    // replace of the top entry, which is legal even when full.
    push_ok_o = push_i & (pop_i ? empty_o : ~full_o);
    pop_ok_o  = pop_i & ~push_i & ~empty_o;
    replace_o = push_i & pop_i & ~empty_o;

    // Guards above keep sp inside 0..DEPTH, so no wrap handling is needed.
    if (push_ok_o) begin
      sp_d = sp_q + SP_W'(1);
    end else if (pop_ok_o) begin
      sp_d = sp_q - SP_W'(1);
    end

    // Set has priority over clear.
    ovf_d = (push_i & ~pop_i & full_o)  | (ovf_q & ~err_clr_i);
    udf_d = (pop_i  & ~push_i & empty_o) | (udf_q & ~err_clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_stack_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_stack_file                                               |
// | Description : DATA_W x DEPTH register bank with two combinational read     |
// |               ports (write-through bypass), one random-access write port   |
// |               and a hardware LIFO sharing the same storage.                |
// | Ports       : clk_i, rst_i                   clock, async active-high rst  |
// |               we_i, waddr_i, wdata_i         random write port             |
// |               raddr_a_i/rdata_a_o            read port A                   |
// |               raddr_b_i/rdata_b_o            read port B                   |
// |               push_i, push_data_i, pop_i     stack requests                |
// |               pop_data_o, pop_valid_o        registered pop result         |
// |               sp_o, full_o, empty_o          stack occupancy               |
// |               overflow_err_o, underflow_err_o, err_clr_i  sticky errors     |
// |               regs_flat_o                    entry i at [i*DATA_W+:DATA_W] |
// | Revision    : 1.0 - initial parametrised release                          |
// +----------------------------------------------------------------------------+
module reg_stack_file
  import reg_stack_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [ADDR_W-1:0]   raddr_a_i,
  output logic [DATA_W-1:0]   rdata_a_o,
  input  logic [ADDR_W-1:0]   raddr_b_i,
  output logic [DATA_W-1:0]   rdata_b_o,
  input  logic                push_i,
  input  logic [DATA_W-1:0]   push_data_i,
  input  logic                pop_i,
  output logic [DATA_W-1:0]   pop_data_o,
  output logic                pop_valid_o,
  output logic [ADDR_W:0]     sp_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                overflow_err_o,
  output logic                underflow_err_o,
  input  logic                err_clr_i,
  output logic [DATA_W*DEPTH-1:0] regs_flat_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              pop_valid_q, pop_valid_d;

  logic [ADDR_W:0]   sp;
  logic              push_ok, pop_ok, replace;
  logic [ADDR_W-1:0] push_idx, top_idx, stack_idx;
  logic              stack_we;

  reg_stack_ptr #(
    .DEPTH (DEPTH),
    .SP_W  (ADDR_W + 1)
  ) u_ptr (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .push_i          (push_i),
    .pop_i           (pop_i),
    .err_clr_i       (err_clr_i),
    .sp_o            (sp),
    .full_o          (full_o),
    .empty_o         (empty_o),
    .push_ok_o       (push_ok),
    .pop_ok_o        (pop_ok),
    .replace_o       (replace),
    .overflow_err_o  (overflow_err_o),
    .underflow_err_o (underflow_err_o)
  );

  // When sp==DEPTH the low bits are 0, so subtracting in ADDR_W bits still
  // lands on DEPTH-1; push_idx is only used when not full.
  assign push_idx  = sp[ADDR_W-1:0];
  assign top_idx   = push_idx - ADDR_W'(1);
  assign stack_we  = push_ok | replace;
  assign stack_idx = replace ? top_idx : push_idx;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    pop_data_d  = pop_data_q;
    pop_valid_d = pop_ok | replace;

    if (pop_ok || replace) pop_data_d = mem_q[top_idx];

    // A random write to the entry the stack is writing this cycle is dropped.
    if (we_i && !(stack_we && (waddr_i == stack_idx))) mem_d[waddr_i] = wdata_i;
    if (stack_we) mem_d[stack_idx] = push_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
    end
  end

  // Bypass covers only the random write port, never push data.
  assign rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : mem_q[raddr_a_i];
  assign rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : mem_q[raddr_b_i];

  assign pop_data_o  = pop_data_q;
  assign pop_valid_o = pop_valid_q;
  assign sp_o        = sp;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign regs_flat_o[g*DATA_W +: DATA_W] = mem_q[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_stack_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_reg_stack_file                                            |
// | Description : Self-checking bench for reg_stack_file (DATA_W=8, DEPTH=4).  |
// |               A stack/array model is compared against every output on     |
// |               each falling edge; literal expectations pin the model.       |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module tb_reg_stack_file;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr, raddr_a, raddr_b;
  logic [DW-1:0] wdata, push_data;
  logic          push, pop, err_clr;
  logic [DW-1:0] rdata_a, rdata_b, pop_data;
  logic          pop_valid, full, empty, ovf, udf;
  logic [AW:0]   sp;
  logic [DW*DP-1:0] regs_flat;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  reg_stack_file #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .we_i            (we),
    .waddr_i         (waddr),
    .wdata_i         (wdata),
    .raddr_a_i       (raddr_a),
    .rdata_a_o       (rdata_a),
    .raddr_b_i       (raddr_b),
    .rdata_b_o       (rdata_b),
    .push_i          (push),
    .push_data_i     (push_data),
    .pop_i           (pop),
    .pop_data_o      (pop_data),
    .pop_valid_o     (pop_valid),
    .sp_o            (sp),
    .full_o          (full),
    .empty_o         (empty),
    .overflow_err_o  (ovf),
    .underflow_err_o (udf),
    .err_clr_i       (err_clr),
    .regs_flat_o     (regs_flat)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [DP];
  int            m_sp;
  logic [DW-1:0] m_pd;
  bit            m_pv, m_ovf, m_udf;
  int            m_idx;
  bit            m_sov, m_sud;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DP; i++) m_mem[i] = '0;
      m_sp = 0; m_pd = '0; m_pv = 0; m_ovf = 0; m_udf = 0;
    end else begin
      m_idx = -1; m_sov = 0; m_sud = 0; m_pv = 0;
      if (push && pop && m_sp > 0) begin
        m_pd = m_mem[m_sp-1]; m_pv = 1;
        m_mem[m_sp-1] = push_data; m_idx = m_sp - 1;
      end else if (push) begin
        if (m_sp < DP) begin
          m_mem[m_sp] = push_data; m_idx = m_sp; m_sp++;
        end else m_sov = 1;
      end else if (pop) begin
        if (m_sp > 0) begin
          m_pd = m_mem[m_sp-1]; m_sp--; m_pv = 1;
        end else m_sud = 1;
      end
      if (we && int'(waddr) != m_idx) m_mem[waddr] = wdata;
      m_ovf = m_sov | (m_ovf & !err_clr);
      m_udf = m_sud | (m_udf & !err_clr);
    end
  end

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    return (we && waddr == a) ? wdata : m_mem[a];
  endfunction

  function automatic logic [DW*DP-1:0] m_flat();
    logic [DW*DP-1:0] f;
    for (int i = 0; i < DP; i++) f[i*DW +: DW] = m_mem[i];
    return f;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rdata_a",   rdata_a,   m_read(raddr_a));
      chk("rdata_b",   rdata_b,   m_read(raddr_b));
      chk("pop_data",  pop_data,  m_pd);
      chk("pop_valid", pop_valid, m_pv);
      chk("sp",        sp,        m_sp);
      chk("full",      full,      m_sp == DP);
      chk("empty",     empty,     m_sp == 0);
      chk("ovf",       ovf,       m_ovf);
      chk("udf",       udf,       m_udf);
      chk("regs_flat", regs_flat, m_flat());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit we_v, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input bit pu, input logic [DW-1:0] pdv, input bit po, input bit clr);
    we = we_v; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
    push = pu; push_data = pdv; pop = po; err_clr = clr;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_push(input logic [DW-1:0] d);
    drive(0, 0, 0, 0, 0, 1, d, 0, 0); tick();
  endtask

  task automatic do_pop();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
  endtask

  task automatic do_idle(input bit clr);
    drive(0, 0, 0, 0, 0, 0, 0, 0, clr); tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pops [4];
    pops = '{8'h44, 8'h33, 8'h22, 8'h11};
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_sp", sp, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_flat", regs_flat, 0);
    chk("rst_pv", pop_valid, 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // 1: fill
    for (int i = 0; i < 4; i++) begin
      do_push(8'(8'h11 * (i + 1)));
      chk("fill_sp", sp, i + 1);
    end
    chk("fill_full", full, 1);
    chk("fill_flat", regs_flat, 32'h44332211);

    // 2: overflow, then clear
    do_push(8'h55);
    chk("ovf_sp", sp, 4);
    chk("ovf_flat", regs_flat, 32'h44332211);
    chk("ovf_set", ovf, 1);
    do_idle(1);
    chk("ovf_clr", ovf, 0);

    // 3: drain and underflow
    for (int i = 0; i < 4; i++) begin
      do_pop();
      chk("pop_data_lit", pop_data, pops[i]);
      chk("pop_valid_lit", pop_valid, 1);
    end
    chk("drain_empty", empty, 1);
    do_pop();
    chk("udf_set", udf, 1);
    chk("udf_pd_hold", pop_data, 8'h11);
    chk("udf_pv", pop_valid, 0);
    do_idle(1);

    // 4: replace top, then push+pop on empty
    do_push(8'hA0);
    drive(0, 0, 0, 0, 0, 1, 8'hB0, 1, 0); tick();
    chk("rep_pd", pop_data, 8'hA0);
    chk("rep_pv", pop_valid, 1);
    chk("rep_sp", sp, 1);
    chk("rep_mem0", regs_flat[7:0], 8'hB0);
    do_pop();
    drive(0, 0, 0, 0, 0, 1, 8'hC0, 1, 0); tick();
    chk("pp_empty_sp", sp, 1);
    chk("pp_empty_udf", udf, 0);

    // 5: write-through bypass
    drive(1, 2, 8'h5A, 2, 0, 0, 0, 0, 0);
    #1;
    chk("bypass_a", rdata_a, 8'h5A);
    tick();
    drive(0, 0, 0, 0, 2, 0, 0, 0, 0);
    #1;
    chk("read_b", rdata_b, 8'h5A);
    tick();

    // 6: push beats colliding write, then reset mid-operation
    drive(1, 1, 8'h99, 1, 1, 1, 8'h77, 0, 0); tick();
    chk("coll_mem1", regs_flat[15:8], 8'h77);
    chk("coll_sp", sp, 2);
    drive(0, 0, 0, 0, 0, 1, 8'h88, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_sp", sp, 0);
    chk("mrst_flat", regs_flat, 0);
    chk("mrst_pd", pop_data, 0);
    chk("mrst_empty", empty, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    // replace while full raises no error
    for (int i = 1; i <= 4; i++) do_push(8'(i));
    drive(0, 0, 0, 0, 0, 1, 8'h66, 1, 0); tick();
    chk("fullrep_pd", pop_data, 8'h04);
    chk("fullrep_sp", sp, 4);
    chk("fullrep_ovf", ovf, 0);
    chk("fullrep_flat", regs_flat, 32'h66030201);
    do_idle(0);
    chk("pv_drop", pop_valid, 0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_stack_file.md
Name: reg_stack_file

Overview:
Parametrised successor to the fixed 4x8 register stack. DATA_W x DEPTH register array with:
- two combinational read ports and one write port, with write-through bypass;
- a hardware LIFO mode (push/pop) on the same array, with overflow/underflow detection.
Sits in the CPU datapath as the general register bank and the call/operand stack. A flattened debug bus replaces per-register outputs.

Parameters:
DATA_W, 8, register width in bits
DEPTH, 4, number of registers (>=2, power of two)
ADDR_W, $clog2(DEPTH), register address width (derived, not overridden)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
we  in  1  random-access write enable
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
raddr_a  in  ADDR_W  read port A address
rdata_a  out  DATA_W  read port A data (combinational)
raddr_b  in  ADDR_W  read port B address
rdata_b  out  DATA_W  read port B data (combinational)
push  in  1  push push_data onto stack
push_data  in  DATA_W  data to push
pop  in  1  pop top of stack
pop_data  out  DATA_W  registered popped value
pop_valid  out  1  one-cycle pulse, pop_data updated
sp  out  ADDR_W+1  stack pointer = number of occupied entries (0..DEPTH)
full  out  1  sp==DEPTH
empty  out  1  sp==0
overflow_err  out  1  sticky: push attempted while full
underflow_err  out  1  sticky: pop attempted while empty
err_clr  in  1  synchronous clear of both sticky flags
regs_flat  out  DATA_W*DEPTH  all registers, entry i at bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset (rst=1, asynchronous):
  - all entries = 0, sp = 0, pop_data = 0;
  - pop_valid = 0, overflow_err = 0, underflow_err = 0;
  - therefore empty = 1, full = 0.
  - Reset mid-operation discards any in-flight push/pop.
- Read ports: rdata_x = mem[raddr_x].
  - Bypass: if we=1 and waddr==raddr_x, rdata_x = wdata in the same cycle.
  - No bypass of push data.
- Random write: we=1 -> mem[waddr] <= wdata next edge; sp unchanged.
- Push only (push=1, pop=0):
  - !full: mem[sp] <= push_data; sp <= sp+1.
  - full: no state change except overflow_err <= 1.
- Pop only (pop=1, push=0):
  - !empty: pop_data <= mem[sp-1]; sp <= sp-1; pop_valid <= 1; the entry keeps its value.
  - empty: underflow_err <= 1; pop_data holds; pop_valid <= 0.
- Push and pop in the same cycle:
  - !empty (replace top): pop_data <= old mem[sp-1]; mem[sp-1] <= push_data; pop_valid <= 1; sp unchanged; no error even when full.
  - empty: behaves as push only, pop ignored, no underflow flag.
- Write port vs stack collision in the same cycle: if we targets the entry written by a push or replace, the stack op wins and the random write to that entry is dropped. Otherwise both take effect.
- pop_valid is 0 in every cycle without a successful pop.
- Sticky flags:
  - set and clear in the same cycle: set wins;
  - err_clr alone: both flags <= 0.
- sp arithmetic is ADDR_W+1 bits and never wraps, because saturation is enforced by the full/empty guards.
- full, empty and regs_flat are combinational from registered state.
- No X on outputs after reset.
- Latency:
  - stack and write effects are visible on reads and regs_flat one cycle after the edge;
  - pop_data and pop_valid are valid the cycle after pop is asserted.

Decomposition:
- Shared package reg_stack_pkg: default DATA_W/DEPTH constants and a clog2 helper function.
- One natural sub-module, reg_stack_ptr: sp counter, full/empty, push/pop qualification, sticky error flags. Outputs push_ok, pop_ok and replace to the array logic in reg_stack_file.

Test Plan:
1. Reset, then push 0x11, 0x22, 0x33, 0x44 (DEPTH=4) -> sp 1,2,3,4; full=1 after 4th; regs_flat=0x44332211.
2. From full, push 0x55 -> sp stays 4, regs unchanged, overflow_err=1. Then err_clr -> overflow_err=0.
3. Pop four times -> pop_data 0x44, 0x33, 0x22, 0x11, each with a pop_valid pulse; empty=1. Fifth pop -> underflow_err=1, pop_data stays 0x11, pop_valid=0.
4. Push 0xA0, then push=pop=1 with 0xB0 -> pop_data=0xA0, pop_valid=1, sp=1, mem[0]=0xB0. Push=pop=1 on empty -> sp=1, no underflow.
5. we=1, waddr=2, wdata=0x5A with raddr_a=2 -> rdata_a=0x5A in the same cycle. Next cycle with we=0 -> rdata_b at raddr 2 = 0x5A.
6. sp=1, push 0x77 with we=1, waddr=1, wdata=0x99 -> mem[1]=0x77 (push wins). Then assert rst mid-sequence -> all outputs return to reset values immediately.
